// File: rtl/three_down_bitcounter.sv
// Loadable down-counter with terminal-count pulse, one-shot or auto-reload.
// Optional DOWN_CNT_GRAY_EN adds a registered Gray-code copy of the count (a_gray).
module three_down_bitcounter #(
  parameter int               WIDTH   = 3,
  parameter logic [WIDTH-1:0] RST_VAL = {WIDTH{1'b1}}
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             auto_reload,
`ifdef DOWN_CNT_GRAY_EN
  output logic [WIDTH-1:0] a_gray,
`endif
  output logic [WIDTH-1:0] a,
  output logic             tc,
  output logic             busy
);

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_DONE = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] reload_q, reload_d;
  logic             tc_q, tc_d;
  logic             busy_q, busy_d;

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    reload_d = reload_q;
    tc_d     = 1'b0;
    if (load) begin
      a_d      = load_val;
      reload_d = load_val;
      state_d  = ST_RUN;
    end else begin
      unique case (state_q)
        ST_RUN: begin
          if (en) begin
            if (a_q != '0) begin
              a_d  = a_q - 1'b1;
              // tc fires only when a decrement lands on zero, never on a load of zero
              tc_d = (a_q == WIDTH'(1));
            end else if (auto_reload) begin
              a_d = reload_q;
            end else begin
              state_d = ST_DONE;
            end
          end
        end
        ST_DONE: begin
          a_d = '0;
        end
      endcase
    end
    busy_d = (state_d == ST_RUN);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_RUN;
      a_q      <= RST_VAL;
      reload_q <= RST_VAL;
      tc_q     <= 1'b0;
      busy_q   <= 1'b1;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      reload_q <= reload_d;
      tc_q     <= tc_d;
      busy_q   <= busy_d;
    end
  end

  assign a    = a_q;
  assign tc   = tc_q;
  assign busy = busy_q;

`ifdef DOWN_CNT_GRAY_EN
  logic [WIDTH-1:0] a_gray_q;

  // Encoded from a_d so the Gray copy updates on the same edge as a
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) a_gray_q <= RST_VAL ^ (RST_VAL >> 1);
    else      a_gray_q <= a_d ^ (a_d >> 1);
  end

  assign a_gray = a_gray_q;
`endif

endmodule

// File: tb/tb_three_down_bitcounter.sv
// Directed self-checking bench for three_down_bitcounter (default WIDTH=3).
module tb_three_down_bitcounter;

  localparam int W = 3;

  logic         clk;
  logic         rst;
  logic         en;
  logic         load;
  logic [W-1:0] load_val;
  logic         auto_reload;
  logic [W-1:0] a;
  logic         tc;
  logic         busy;
`ifdef DOWN_CNT_GRAY_EN
  logic [W-1:0] a_gray;
`endif

  int n_checks = 0;
  int n_errors = 0;

  three_down_bitcounter #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .load        (load),
    .load_val    (load_val),
    .auto_reload (auto_reload),
`ifdef DOWN_CNT_GRAY_EN
    .a_gray      (a_gray),
`endif
    .a           (a),
    .tc          (tc),
    .busy        (busy)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // advance one rising edge, then sample 1 time unit later
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [W-1:0] v);
    load     = 1'b1;
    load_val = v;
    step();
    load     = 1'b0;
  endtask

  initial begin : main
    int tc_hi;
    int tc_run;
    logic [W-1:0] exp_a;
    logic [W-1:0] gray_tab [8];
    logic [W-1:0] prev_gray;
    gray_tab = '{3'b100, 3'b101, 3'b111, 3'b110, 3'b010, 3'b011, 3'b001, 3'b000};

    rst = 1'b0; en = 1'b0; load = 1'b0; load_val = '0; auto_reload = 1'b0;
    #12;
    check("rst_a", a, 7);
    check("rst_tc", tc, 0);
    check("rst_busy", busy, 1);
`ifdef DOWN_CNT_GRAY_EN
    check("rst_gray", a_gray, 3'b100);
`endif

    // scenario 1: one-shot countdown from reset value
    step();
    rst = 1'b1;
    en  = 1'b1;
    check("s1_a7", a, 7);
`ifdef DOWN_CNT_GRAY_EN
    prev_gray = a_gray;
`endif
    for (int i = 6; i >= 0; i--) begin
      step();
      check("s1_a", a, i);
      check("s1_tc", tc, (i == 0) ? 1 : 0);
      check("s1_busy", busy, 1);
`ifdef DOWN_CNT_GRAY_EN
      check("s1_gray", a_gray, gray_tab[7-i]);
      check("s1_hamming", $countones(a_gray ^ prev_gray), 1);
      prev_gray = a_gray;
`endif
    end
    step();
    check("s1_done_busy", busy, 0);
    check("s1_done_tc", tc, 0);
    check("s1_done_a", a, 0);
    for (int i = 0; i < 10; i++) begin
      step();
      check("s1_hold_a", a, 0);
      check("s1_hold_busy", busy, 0);
      check("s1_hold_tc", tc, 0);
    end

    // scenario 2: auto-reload with R=3, period 4
    auto_reload = 1'b1;
    do_load(3);
    check("s2_load_a", a, 3);
    check("s2_load_busy", busy, 1);
    check("s2_load_tc", tc, 0);
    tc_hi = 0;
    exp_a = 3;
    for (int i = 0; i < 11; i++) begin
      exp_a = (exp_a == 0) ? 3'd3 : exp_a - 3'd1;
      step();
      check("s2_a", a, exp_a);
      check("s2_tc", tc, (exp_a == 0) ? 1 : 0);
      if (tc) tc_hi++;
    end
    check("s2_tc_count", tc_hi, 3);

    // scenario 3: en toggling every cycle from 5
    auto_reload = 1'b0;
    en = 1'b0;
    do_load(5);
    check("s3_load_a", a, 5);
    tc_run = 0;
    for (int i = 0; i < 12; i++) begin
      en = i[0];
      step();
      case (i)
        0:       exp_a = 5;
        1, 2:    exp_a = 4;
        3, 4:    exp_a = 3;
        5, 6:    exp_a = 2;
        7, 8:    exp_a = 1;
        default: exp_a = 0;
      endcase
      check("s3_a", a, exp_a);
      check("s3_tc", tc, (i == 9) ? 1 : 0);
      tc_run = tc ? tc_run + 1 : 0;
      check("s3_tc_pulse", (tc_run > 1) ? 1 : 0, 0);
    end
    check("s3_busy_done", busy, 0);

    // scenario 4: load beats en; restart from DONE
    en = 1'b0;
    do_load(4);
    check("s4_a4", a, 4);
    en = 1'b1;
    do_load(6);
    check("s4_load_wins", a, 6);
    for (int i = 0; i < 7; i++) step();
    check("s4_done_a", a, 0);
    check("s4_done_busy", busy, 0);
    do_load(2);
    check("s4_restart_a", a, 2);
    check("s4_restart_busy", busy, 1);
    check("s4_restart_tc", tc, 0);
    step();
    check("s4_after_a", a, 1);

    // load of zero: no tc, next en edge goes to DONE in one-shot
    en = 1'b0;
    do_load(0);
    check("z_a", a, 0);
    check("z_tc", tc, 0);
    check("z_busy", busy, 1);
    en = 1'b1;
    step();
    check("z_done_busy", busy, 0);
    check("z_done_tc", tc, 0);

    // scenario 5: async reset mid-count
    do_load(4);
    step();
    step();
    check("s5_pre_a", a, 2);
    #2;
    rst = 1'b0;
    #1;
    check("s5_async_a", a, 7);
    check("s5_async_tc", tc, 0);
    check("s5_async_busy", busy, 1);
    rst = 1'b1;
    step();
    check("s5_resume_a", a, 6);
    step();
    check("s5_resume_a2", a, 5);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/three_down_bitcounter.md
Name: three_down_bitcounter

Overview:
- Loadable down-counter. It is the counterpart to the team's 3-bit up-counter: it counts toward zero instead of away from it.
- Signals terminal count and supports two modes:
  - One-shot: stop at zero.
  - Auto-reload: wrap back to a stored reload value.
- Used as a countdown/timeout timer alongside the up-counter in the counter blocks. Default width is 3 bits so the two blocks drop into the same benches.

Parameters:
- WIDTH, 3, counter and load-value width in bits (min 2).
- RST_VAL, {WIDTH{1'b1}} (7 at default), value loaded into count and reload register on reset.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-low reset (0 = reset asserted).
- en  input  1  count enable; decrement only when 1.
- load  input  1  synchronous load strobe; captures load_val.
- load_val  input  WIDTH  value for count and reload register on load.
- auto_reload  input  1  1 = wrap to reload register at zero; 0 = one-shot stop at zero.
- a  output  WIDTH  current count, registered.
- tc  output  1  terminal-count pulse, registered.
- busy  output  1  1 while in RUN state, registered.

Behaviour:
- Reset (rst=0, async, no clock needed):
  - a=RST_VAL, reload_reg=RST_VAL, tc=0, busy=1, state=RUN.
  - Release is synchronous to the next rising clk; the first decrement can occur on the first edge after release.
- States: RUN, DONE.
- Priority per edge: rst > load > en.
- load=1 (any state):
  - a<=load_val, reload_reg<=load_val, state<=RUN, busy<=1, tc<=0.
  - en is ignored that cycle.
- RUN, en=1, a!=0: a<=a-1.
  - When a==1 this edge makes a=0 and tc<=1 on the same edge, so tc and a==0 appear together for one cycle.
- RUN, en=1, a==0:
  - auto_reload=1: a<=reload_reg, tc<=0, stay RUN.
  - auto_reload=0: a holds 0, tc<=0, state<=DONE, busy<=0.
- RUN, en=0: a, tc hold except tc clears to 0 (tc is a single-cycle pulse).
- DONE: a held 0, tc=0, busy=0. en ignored. Exit only via load or rst.
- Load with load_val=0:
  - a=0 and RUN.
  - No tc pulse for that load (tc only fires on a decrement into 0).
  - The next en edge applies the a==0 rule above (reload or DONE).
- Arithmetic: unsigned modulo 2^WIDTH; no underflow past 0 in either mode.
- Count period in auto-reload mode with reload value R (R>0): R+1 enabled cycles; tc once per period.
- rst asserted mid-count: immediate return to reset values regardless of state, load or en.
- All outputs glitch-free registered; no combinational path from inputs to outputs.

Optional Feature:
- Macro DOWN_CNT_GRAY_EN.
- Defined: adds output port a_gray [WIDTH-1:0], a registered Gray-code copy of the next count (a_gray = a ^ (a>>1), registered in the same edge as a). Reset value is RST_VAL ^ (RST_VAL>>1), i.e. 3'b100 at default. Exactly one bit changes per decrement, except on load/reload.
- Not defined: port a_gray absent; no extra registers; all other behaviour identical.

Test Plan:
- Reset, then en=1 continuously, auto_reload=0, no load:
  - a sequence is 7,6,5,4,3,2,1,0.
  - tc=1 only in the cycle a first reads 0.
  - busy drops to 0 one edge later; a stays 0 for 10 more cycles.
- load=1, load_val=3, then en=1, auto_reload=1 for 12 cycles:
  - a = 3,2,1,0,3,2,1,0,3,2,1,0.
  - tc high exactly 3 times, each coincident with a==0.
- en toggled 1/0 every cycle from a=5:
  - a decrements only on en=1 edges: 5,5,4,4,3…
  - tc never stays high more than 1 cycle.
- load and en both 1 in the same cycle with a=4, load_val=6: a becomes 6 (load wins, no decrement); from DONE, load_val=2 restarts with busy=1.
- Assert rst=0 asynchronously mid-count at a=2 between clock edges: a=7, tc=0, busy=1 immediately, before the next clk edge; counting resumes after release.
- With DOWN_CNT_GRAY_EN defined: repeat scenario 1 and check a_gray = 100,101,111,110,010,011,001,000 and a Hamming distance of 1 between consecutive values.
